// File: rtl/uart_rx_fifo_if.sv
// Byte bus between the UART receiver/consumer side and the receive FIFO.
// The master drives the receiver level, byte and read/clear controls; the slave returns status.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic              clr_ovf;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output rx_valid, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_valid, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: rising rx_valid writes a byte (1-cycle latency); reads return data 1 cycle after rd_en.
// No backpressure to the receiver: writes while full are dropped and latch a sticky overflow flag.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic           sys_clk_i,
  input  logic           rst_n_i,
  uart_rx_fifo_if.slave  bus
);

  logic [7:0]        mem_q [DEPTH];
  logic              rv_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;

  logic              full_w, empty_w;
  logic              wr_stb, wr_acc, rd_acc;

  // Status comes only from the registered count, so no input reaches these outputs combinationally.
  assign full_w  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_w = (count_q == '0);

  assign wr_stb = bus.rx_valid & ~rv_q;
  assign wr_acc = wr_stb & ~full_w;
  assign rd_acc = bus.rd_en & ~empty_w;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + (ADDR_W)'(1);

    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + (ADDR_W)'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    // A dropped byte in the same cycle as a clear keeps the flag set.
    if (wr_stb && full_w)  ovf_d = 1'b1;
    else if (bus.clr_ovf)  ovf_d = 1'b0;
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rv_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rv_q       <= bus.rx_valid;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: inputs change and outputs are sampled 1ns after each rising edge.
module tb_uart_rx_fifo;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  uart_rx_fifo_if #(.ADDR_W(4)) bus ();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .sys_clk_i (sys_clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Low for one sampled edge then high: the byte lands on the second edge.
  task automatic put_byte(input logic [7:0] b);
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic read_expect(input string name, input logic [7:0] exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
      failures++;
      $display("FAIL %s: rd_valid=%b rd_data=%h, required rd_valid=1 rd_data=%h",
               name, bus.rd_valid, bus.rd_data, exp);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h5A;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst_n = 1'b0;
    #23;
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.full !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: empty=%b count=%0d full=%b rd_valid=%b rd_data=%h ovf=%b, required 1 0 0 0 00 0",
               bus.empty, bus.count, bus.full, bus.rd_valid, bus.rd_data, bus.overflow);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle: %0d cycles showed a write or read, required 0", bad);
    end
  endtask

  task automatic test_single();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.rx_data  = 8'hA5;
    bus.rx_valid = 1'b1;
    tick();
    checks++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL single_write: count=%0d empty=%b, required 1 0", bus.count, bus.empty);
    end
    read_expect("single_read", 8'hA5);
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      failures++;
      $display("FAIL single_empty: empty=%b count=%0d, required 1 0", bus.empty, bus.count);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_pulse: rd_valid=%b rd_data=%h, required 0 a5", bus.rd_valid, bus.rd_data);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
      failures++;
      $display("FAIL read_empty: rd_valid=%b count=%0d, required 0 0", bus.rd_valid, bus.count);
    end
  endtask

  task automatic test_fill_wrap();
    int bad;
    for (int i = 0; i < 16; i++) put_byte(8'(i));
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 5'd16) begin
      failures++;
      $display("FAIL fill: full=%b count=%0d, required 1 16", bus.full, bus.count);
    end
    bad = 0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) bad++;
    end
    bus.rd_en = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL drain_order: %0d bytes out of order, required 0", bad);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_end: rd_valid=%b empty=%b, required 0 1", bus.rd_valid, bus.empty);
    end
    bad = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) put_byte(8'h40 + 8'(r * 10 + i));
      for (int i = 0; i < 10; i++) begin
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h40 + 8'(r * 10 + i)) bad++;
      end
    end
    checks++;
    if (bad !== 0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_order: %0d bad bytes empty=%b, required 0 1", bad, bus.empty);
    end
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < 16; i++) put_byte(8'h80 + 8'(i));
    put_byte(8'hFF);
    checks++;
    if (bus.count !== 5'd16 || bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: count=%0d ovf=%b full=%b, required 16 1 1",
               bus.count, bus.overflow, bus.full);
    end
    tick();
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%b, required 1", bus.overflow);
    end
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: ovf=%b, required 0", bus.overflow);
    end
    bad = 0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.rd_data !== 8'h80 + 8'(i)) bad++;
    end
    bus.rd_en = 1'b0;
    tick();
    checks++;
    if (bad !== 0 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL overflow_readout: %0d bad bytes empty=%b, required 0 1", bad, bus.empty);
    end
  endtask

  task automatic test_simultaneous();
    put_byte(8'h11);
    put_byte(8'h22);
    put_byte(8'h33);
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = 8'h44;
    bus.rx_valid = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.count !== 5'd3 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h11) begin
      failures++;
      $display("FAIL simul_mid: count=%0d rd_valid=%b rd_data=%h, required 3 1 11",
               bus.count, bus.rd_valid, bus.rd_data);
    end
    read_expect("simul_r22", 8'h22);
    read_expect("simul_r33", 8'h33);
    read_expect("simul_r44", 8'h44);
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.count !== 5'd1 || bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_empty: count=%0d rd_valid=%b, required 1 0", bus.count, bus.rd_valid);
    end
    read_expect("simul_r55", 8'h55);
    for (int i = 0; i < 16; i++) put_byte(8'hC0 + 8'(i));
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = 8'hEE;
    bus.rx_valid = 1'b1;
    bus.rd_en    = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    checks++;
    if (bus.count !== 5'd15 || bus.overflow !== 1'b1 || bus.rd_data !== 8'hC0) begin
      failures++;
      $display("FAIL simul_full: count=%0d ovf=%b rd_data=%h, required 15 1 c0",
               bus.count, bus.overflow, bus.rd_data);
    end
    put_byte(8'hEF);
    bus.rx_valid = 1'b0;
    tick();
    bus.rx_data  = 8'hF0;
    bus.rx_valid = 1'b1;
    bus.clr_ovf  = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      failures++;
      $display("FAIL set_beats_clear: ovf=%b count=%0d, required 1 16", bus.overflow, bus.count);
    end
    read_expect("simul_rC1", 8'hC1);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) put_byte(8'h60 + 8'(i));
    read_expect("pre_reset_read", 8'h60);
    checks++;
    if (bus.count !== 5'd5) begin
      failures++;
      $display("FAIL pre_reset_count: count=%0d, required 5", bus.count);
    end
    bus.rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 || bus.overflow !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: count=%0d empty=%b full=%b rd_valid=%b rd_data=%h ovf=%b, required 0 1 0 0 00 0",
               bus.count, bus.empty, bus.full, bus.rd_valid, bus.rd_data, bus.overflow);
    end
    tick();
    rst_n = 1'b1;
    tick();
    bus.rx_data  = 8'h3C;
    bus.rx_valid = 1'b1;
    tick();
    checks++;
    if (bus.count !== 5'd1) begin
      failures++;
      $display("FAIL post_reset_write: count=%0d, required 1", bus.count);
    end
    read_expect("post_reset_read", 8'h3C);
  endtask

  initial begin
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
